// File: rtl/line_deserializer.sv
// rtl/line_deserializer.sv - assembles WORDS memory words into one cache line with valid/ready output
// Optional critical-word-first fill enabled by defining DESER_CWF_EN.
module line_deserializer #(
   parameter int WORD_W = 32,
   parameter int WORDS  = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WORD_W-1:0]         in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      flush,
`ifdef DESER_CWF_EN
   input  logic [$clog2(WORDS)-1:0]  start_idx,
   output logic                      crit_valid,
`endif
   output logic [WORDS*WORD_W-1:0]   line_data,
   output logic                      line_valid,
   input  logic                      line_ready,
   output logic [$clog2(WORDS):0]    fill_count
);

   localparam int IW = $clog2(WORDS);
   localparam int CW = IW + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_FULL} state_e;

   state_e                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [IW-1:0]           base_idx, wr_idx;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [WORDS*WORD_W-1:0] line_q, line_d;
   logic                    valid_q, valid_d;
   logic                    crit_q, crit_d;
   logic                    accept;

`ifdef DESER_CWF_EN
   assign base_idx   = start_idx;
   assign crit_valid = crit_q;
`else
   assign base_idx   = '0;
`endif

   assign in_ready   = rst_n && (state_q != S_FULL);
   assign accept     = in_valid && in_ready;
   // Only the accept leaving IDLE takes its slot from the base index.
   assign wr_idx     = (state_q == S_IDLE) ? base_idx : idx_q;
   assign line_data  = line_q;
   assign line_valid = valid_q;
   assign fill_count = cnt_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      line_d  = line_q;
      valid_d = valid_q;
      crit_d  = 1'b0;
      if (flush) begin
         state_d = S_IDLE;
         idx_d   = '0;
         cnt_d   = '0;
         valid_d = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  line_d[wr_idx*WORD_W +: WORD_W] = in_data;
                  idx_d   = wr_idx + IW'(1);
                  cnt_d   = CW'(1);
                  crit_d  = 1'b1;
                  state_d = S_FILL;
               end
            end
            S_FILL: begin
               if (accept) begin
                  line_d[wr_idx*WORD_W +: WORD_W] = in_data;
                  idx_d = wr_idx + IW'(1);
                  cnt_d = cnt_q + CW'(1);
                  if (cnt_q == LAST_CNT) begin
                     state_d = S_FULL;
                     valid_d = 1'b1;
                  end
               end
            end
            S_FULL: begin
               if (valid_q && line_ready) begin
                  state_d = S_IDLE;
                  idx_d   = '0;
                  cnt_d   = '0;
                  valid_d = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         line_q  <= '0;
         valid_q <= 1'b0;
         crit_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
         valid_q <= valid_d;
         crit_q  <= crit_d;
      end
   end

endmodule

// File: tb/tb_line_deserializer.sv
// tb/tb_line_deserializer.sv - directed self-checking bench for line_deserializer
module tb_line_deserializer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [31:0]  in_data;
   logic         in_valid;
   logic         in_ready;
   logic         flush;
   logic [255:0] line_data;
   logic         line_valid;
   logic         line_ready;
   logic [3:0]   fill_count;
`ifdef DESER_CWF_EN
   logic [2:0]   start_idx;
   logic         crit_valid;
`endif

   int checks   = 0;
   int failures = 0;

   line_deserializer #(.WORD_W(32), .WORDS(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .flush      (flush),
`ifdef DESER_CWF_EN
      .start_idx  (start_idx),
      .crit_valid (crit_valid),
`endif
      .line_data  (line_data),
      .line_valid (line_valid),
      .line_ready (line_ready),
      .fill_count (fill_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [255:0] l, input int k);
      return l[k*32 +: 32];
   endfunction

   task automatic send_word(input logic [31:0] w, input int gap);
      in_data  = w;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 32'hBAD0_0000 + 32'(gap);
      repeat (gap) @(negedge clk);
   endtask

   task automatic drain();
      line_ready = 1'b1;
      @(negedge clk);
      line_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; line_ready = 1'b0;
`ifdef DESER_CWF_EN
      start_idx = '0;
`endif
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if (line_valid !== 1'b0) begin failures++; $display("FAIL reset_line_valid got=%b exp=0", line_valid); end
      checks++; if (fill_count !== 4'd0) begin failures++; $display("FAIL reset_fill_count got=%0d exp=0", fill_count); end
      checks++; if (line_data !== 256'd0) begin failures++; $display("FAIL reset_line_data got=%h exp=0", line_data); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_full_fill();
      for (int i = 0; i < 8; i++) begin
         in_data  = 32'h1000_0000 + 32'(i);
         in_valid = 1'b1;
         @(negedge clk);
         checks++; if (fill_count !== 4'(i + 1)) begin failures++; $display("FAIL fill_count_%0d got=%0d exp=%0d", i, fill_count, i + 1); end
         checks++; if (line_valid !== (i == 7)) begin failures++; $display("FAIL fill_valid_%0d got=%b exp=%b", i, line_valid, (i == 7)); end
      end
      in_data = 32'hDEAD_BEEF;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
      checks++; if (word_of(line_data, 0) !== 32'h1000_0000) begin failures++; $display("FAIL full_word0 got=%h exp=10000000", word_of(line_data, 0)); end
      checks++; if (word_of(line_data, 7) !== 32'h1000_0007) begin failures++; $display("FAIL full_word7 got=%h exp=10000007", word_of(line_data, 7)); end
      repeat (2) @(negedge clk);
      checks++; if (word_of(line_data, 0) !== 32'h1000_0000) begin failures++; $display("FAIL held_word0 got=%h exp=10000000", word_of(line_data, 0)); end
      checks++; if (fill_count !== 4'd8) begin failures++; $display("FAIL held_fill_count got=%0d exp=8", fill_count); end
      checks++; if (line_valid !== 1'b1) begin failures++; $display("FAIL held_line_valid got=%b exp=1", line_valid); end
      in_valid = 1'b0;
   endtask

   task automatic test_handshake();
      drain();
      checks++; if (line_valid !== 1'b0) begin failures++; $display("FAIL hs_line_valid got=%b exp=0", line_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hs_in_ready got=%b exp=1", in_ready); end
      checks++; if (fill_count !== 4'd0) begin failures++; $display("FAIL hs_fill_count got=%0d exp=0", fill_count); end
      for (int i = 0; i < 8; i++) send_word(32'hA000_0000 + 32'(i), 0);
      for (int k = 0; k < 8; k++) begin
         checks++; if (word_of(line_data, k) !== 32'hA000_0000 + 32'(k)) begin failures++; $display("FAIL hs_word%0d got=%h exp=%h", k, word_of(line_data, k), 32'hA000_0000 + 32'(k)); end
      end
      drain();
   endtask

   task automatic test_toggle_valid();
      for (int i = 0; i < 7; i++) send_word(32'h2000_0000 + 32'(i), 1);
      checks++; if (line_valid !== 1'b0) begin failures++; $display("FAIL toggle_early_valid got=%b exp=0", line_valid); end
      checks++; if (fill_count !== 4'd7) begin failures++; $display("FAIL toggle_count7 got=%0d exp=7", fill_count); end
      send_word(32'h2000_0007, 0);
      checks++; if (line_valid !== 1'b1) begin failures++; $display("FAIL toggle_valid got=%b exp=1", line_valid); end
      for (int k = 0; k < 8; k++) begin
         checks++; if (word_of(line_data, k) !== 32'h2000_0000 + 32'(k)) begin failures++; $display("FAIL toggle_word%0d got=%h exp=%h", k, word_of(line_data, k), 32'h2000_0000 + 32'(k)); end
      end
      drain();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) send_word(32'h3000_0000 + 32'(i), 0);
      checks++; if (fill_count !== 4'd3) begin failures++; $display("FAIL pre_flush_count got=%0d exp=3", fill_count); end
      flush = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (fill_count !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", fill_count); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
      for (int i = 0; i < 8; i++) send_word(32'h4000_0000 + 32'(i), 0);
      checks++; if (line_valid !== 1'b1) begin failures++; $display("FAIL post_flush_valid got=%b exp=1", line_valid); end
      checks++; if (word_of(line_data, 0) !== 32'h4000_0000) begin failures++; $display("FAIL post_flush_word0 got=%h exp=40000000", word_of(line_data, 0)); end
      checks++; if (word_of(line_data, 7) !== 32'h4000_0007) begin failures++; $display("FAIL post_flush_word7 got=%h exp=40000007", word_of(line_data, 7)); end
      flush = 1'b1; line_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; line_ready = 1'b0;
      checks++; if (line_valid !== 1'b0) begin failures++; $display("FAIL flush_full_valid got=%b exp=0", line_valid); end
      checks++; if (fill_count !== 4'd0) begin failures++; $display("FAIL flush_full_count got=%0d exp=0", fill_count); end
   endtask

   task automatic test_reset_full();
      for (int i = 0; i < 8; i++) send_word(32'h5000_0000 + 32'(i), 0);
      checks++; if (line_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%b exp=1", line_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_comb_in_ready got=%b exp=0", in_ready); end
      @(negedge clk);
      checks++; if (line_valid !== 1'b0) begin failures++; $display("FAIL rst_full_valid got=%b exp=0", line_valid); end
      checks++; if (line_data !== 256'd0) begin failures++; $display("FAIL rst_full_data got=%h exp=0", line_data); end
      checks++; if (fill_count !== 4'd0) begin failures++; $display("FAIL rst_full_count got=%0d exp=0", fill_count); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
   endtask

`ifdef DESER_CWF_EN
   task automatic test_cwf();
      start_idx = 3'd5;
      send_word(32'hC000_0000, 0);
      start_idx = 3'd0;
      checks++; if (crit_valid !== 1'b1) begin failures++; $display("FAIL cwf_crit_pulse got=%b exp=1", crit_valid); end
      checks++; if (word_of(line_data, 5) !== 32'hC000_0000) begin failures++; $display("FAIL cwf_crit_word got=%h exp=c0000000", word_of(line_data, 5)); end
      send_word(32'hC000_0001, 0);
      checks++; if (crit_valid !== 1'b0) begin failures++; $display("FAIL cwf_crit_end got=%b exp=0", crit_valid); end
      for (int i = 2; i < 8; i++) send_word(32'hC000_0000 + 32'(i), 0);
      checks++; if (line_valid !== 1'b1) begin failures++; $display("FAIL cwf_valid got=%b exp=1", line_valid); end
      checks++; if (word_of(line_data, 0) !== 32'hC000_0003) begin failures++; $display("FAIL cwf_word0 got=%h exp=c0000003", word_of(line_data, 0)); end
      checks++; if (word_of(line_data, 7) !== 32'hC000_0002) begin failures++; $display("FAIL cwf_word7 got=%h exp=c0000002", word_of(line_data, 7)); end
      checks++; if (word_of(line_data, 5) !== 32'hC000_0000) begin failures++; $display("FAIL cwf_word5 got=%h exp=c0000000", word_of(line_data, 5)); end
      drain();
   endtask
`endif

   initial begin
      test_reset();
      test_full_fill();
      test_handshake();
      test_toggle_valid();
      test_flush();
      test_reset_full();
`ifdef DESER_CWF_EN
      test_cwf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/line_deserializer.md
Name: line_deserializer

Overview:
- Memory-fill stage for the cache line path; the mirror of the write-back serializer.
- Accepts a stream of WORD_W-bit words from the memory interface and assembles WORDS of them into one WORDS*WORD_W-bit line.
- Presents the line to the cache fill logic with a valid/ready handshake.
- Sits between the memory read-data bus and the cache data-array write port.

Parameters:
- WORD_W, 32, width of one memory word in bits.
- WORDS, 8, words per cache line. Power of two, at least 2.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  WORD_W  memory read word.
- in_valid  input  1  in_data valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- flush  input  1  synchronous abort of a partial fill.
- line_data  output  WORDS*WORD_W  assembled line; word k sits at bits [k*WORD_W +: WORD_W].
- line_valid  output  1  line_data complete and stable.
- line_ready  input  1  cache consumes the line this cycle.
- fill_count  output  $clog2(WORDS)+1  words accepted into the current line (0..WORDS).

Behaviour:
- Reset: one clock, synchronous, active-low. While rst_n=0 at a rising edge: state=IDLE, fill_count=0, line_valid=0, line_data=0, write index=0.
- in_ready is combinationally 0 whenever rst_n=0.
- Accept: a word is accepted on an edge where in_valid && in_ready. No other edge changes the line registers.
- States:
  - IDLE: fill_count=0; in_ready=1. Accept -> store the word at the write index, fill_count=1, go to FILL.
  - FILL: in_ready=1. Each accept stores the word at the write index, increments the index modulo WORDS, and increments fill_count. When the accept brings fill_count to WORDS, go to FULL.
  - FULL: in_ready=0; line_valid=1 (registered; asserted the cycle after the WORDS-th accept). line_data is held constant. On line_valid && line_ready: go to IDLE, line_valid=0, fill_count=0, index = base (0). in_ready returns to 1 the cycle after the handshake; there is no same-cycle bypass.
- Without the optional feature, word order is in_data #0 -> word 0 (LSBs) through #WORDS-1 -> word WORDS-1. This matches the serializer, which emits word 0 first.
- Latency: last word accepted at edge N -> line_valid=1 after edge N. A back-to-back fill takes WORDS accept cycles + 1 FULL cycle minimum.
- in_valid while in_ready=0 is ignored. The upstream must hold the word.
- flush=1 on an edge, in any state: go to IDLE, fill_count=0, line_valid=0, index=0. line_data contents are don't-care.
  - flush has priority over a simultaneous accept (the word is dropped) and over a simultaneous line handshake (the line is discarded).
- fill_count never exceeds WORDS. The index wraps from WORDS-1 to 0.
- Reset mid-fill or with line_valid=1 behaves as flush and also zeroes line_data.

Optional Feature:
- Macro: DESER_CWF_EN (critical-word-first).
- Defined:
  - Adds input start_idx, width $clog2(WORDS). It is sampled only on the accept that leaves IDLE.
  - The first word is stored at word start_idx. Later words go to (start_idx+i) mod WORDS.
  - Adds output crit_valid, 1 bit, registered. It pulses high for one cycle after the first accept of a fill, with line_data word start_idx already valid, so the core can restart early.
  - flush and reset clear crit_valid.
- Not defined: no start_idx or crit_valid ports; the base index is always 0.

Test Plan:
- Reset, then in_valid held with words 0x1000_0000..0x1000_0007, line_ready=0 -> in_ready=0 and line_valid=1 after the 8th accept; line_data[31:0]=0x1000_0000, [255:224]=0x1000_0007; fill_count=8.
- Same fill with in_valid toggling every other cycle -> 15 cycles to fill; only 8 words captured; no word lost or duplicated.
- FULL with line_ready=1 for 1 cycle -> line_valid=0 the next cycle and in_ready=1; the next fill of 0xA..0xH starts at word 0.
- Accept 3 words, then flush=1 together with in_valid=1 -> fill_count=0, state IDLE, flushed word dropped. Next 8 words form a clean line.
- Assert rst_n=0 with line_valid=1 -> line_valid=0, line_data=0, in_ready=0 during reset, fill_count=0.
- DESER_CWF_EN with start_idx=5 and words W0..W7 -> W0 in word 5, W3 in word 0, W2 in word 7; crit_valid pulses once after the first accept; line_valid after the 8th accept.
